// File: rtl/unpack_s3_piso.sv
`default_nettype none
// ============================================================================
// unpack_s3_piso : pack_S3 byte -> base-3 trit stream (5 trits/byte, t0 first)
// Revision: 1.0
// ============================================================================
module unpack_s3_piso #(
  parameter int NUM_COEF = 700,
  parameter int CW       = 10
) (
  input  logic          ex_clk,
  input  logic          ovr_rst1_n,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic [1:0]    trit_out,
  output logic          trit_valid,
  input  logic          trit_ready,
  output logic          trit_last,
  output logic [CW-1:0] coef_idx,
  output logic          busy,
  output logic          done,
  output logic          fmt_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_COEF - 1);
  localparam logic [7:0]    MAX_BYTE = 8'd242;

  state_t        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    trit_cnt_q, trit_cnt_d;
  logic [CW-1:0] coef_cnt_q, coef_cnt_d;
  logic          fmt_err_q, fmt_err_d;
  logic [1:0]    sh_mod3;
  logic [7:0]    sh_div3;

  always_comb begin
    sh_mod3 = 2'(sh_q % 8'd3);
    sh_div3 = sh_q / 8'd3;
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    trit_cnt_d = trit_cnt_q;
    coef_cnt_d = coef_cnt_q;
    fmt_err_d  = fmt_err_q;
    byte_ready = 1'b0;
    trit_valid = 1'b0;
    trit_out   = 2'd0;
    trit_last  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          fmt_err_d  = 1'b0;
          trit_cnt_d = '0;
          coef_cnt_d = '0;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          sh_d       = byte_in;
          trit_cnt_d = '0;
          state_d    = EMIT;
          // Out-of-range bytes are flagged but still decoded digit by digit.
          if (byte_in > MAX_BYTE) fmt_err_d = 1'b1;
        end
      end
      EMIT: begin
        trit_valid = 1'b1;
        trit_out   = sh_mod3;
        trit_last  = (coef_cnt_q == LAST_IDX);
        if (trit_ready) begin
          sh_d       = sh_div3;
          trit_cnt_d = trit_cnt_q + 3'd1;
          coef_cnt_d = coef_cnt_q + CW'(1);
          if (coef_cnt_q == LAST_IDX)  state_d = DONE;
          else if (trit_cnt_q == 3'd4) state_d = LOAD;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_d    = IDLE;
        sh_d       = '0;
        trit_cnt_d = '0;
        coef_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ex_clk) begin
    if (!ovr_rst1_n) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      trit_cnt_q <= '0;
      coef_cnt_q <= '0;
      fmt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      trit_cnt_q <= trit_cnt_d;
      coef_cnt_q <= coef_cnt_d;
      fmt_err_q  <= fmt_err_d;
    end
  end

  assign coef_idx = coef_cnt_q;
  assign fmt_err  = fmt_err_q;

endmodule
`default_nettype wire

// File: tb/tb_unpack_s3_piso.sv
`default_nettype none
// Bench for unpack_s3_piso: directed steps plus a randomized full polynomial
// checked against a digit-extraction reference queue.
module tb_unpack_s3_piso;

  localparam int CW = 10;
  localparam int N0 = 700;
  localparam int N1 = 7;

  logic ex_clk = 1'b0;
  always #5 ex_clk = ~ex_clk;

  logic          rst_n      [2];
  logic          start      [2];
  logic [7:0]    byte_in    [2];
  logic          byte_valid [2];
  logic          byte_ready [2];
  logic [1:0]    trit_out   [2];
  logic          trit_valid [2];
  logic          trit_ready [2];
  logic          trit_last  [2];
  logic [CW-1:0] coef_idx   [2];
  logic          busy       [2];
  logic          done       [2];
  logic          fmt_err    [2];

  int n_cmp = 0;
  int n_err = 0;

  unpack_s3_piso #(.NUM_COEF(N0), .CW(CW)) u_dut0 (
    .ex_clk(ex_clk), .ovr_rst1_n(rst_n[0]), .start(start[0]),
    .byte_in(byte_in[0]), .byte_valid(byte_valid[0]), .byte_ready(byte_ready[0]),
    .trit_out(trit_out[0]), .trit_valid(trit_valid[0]), .trit_ready(trit_ready[0]),
    .trit_last(trit_last[0]), .coef_idx(coef_idx[0]), .busy(busy[0]),
    .done(done[0]), .fmt_err(fmt_err[0])
  );

  unpack_s3_piso #(.NUM_COEF(N1), .CW(CW)) u_dut1 (
    .ex_clk(ex_clk), .ovr_rst1_n(rst_n[1]), .start(start[1]),
    .byte_in(byte_in[1]), .byte_valid(byte_valid[1]), .byte_ready(byte_ready[1]),
    .trit_out(trit_out[1]), .trit_valid(trit_valid[1]), .trit_ready(trit_ready[1]),
    .trit_last(trit_last[1]), .coef_idx(coef_idx[1]), .busy(busy[1]),
    .done(done[1]), .fmt_err(fmt_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ex_clk);
    #1;
  endtask

  // i-th base-3 digit of b, least significant first
  function automatic logic [1:0] digit(input int b, input int i);
    int v;
    v = b;
    for (int k = 0; k < i; k++) v = v / 3;
    return 2'(v % 3);
  endfunction

  function automatic int nc(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic logic [31:0] all_out(input int d);
    return 32'({byte_ready[d], trit_valid[d], trit_last[d], trit_out[d],
                coef_idx[d], busy[d], done[d], fmt_err[d]});
  endfunction

  // Feed one byte with trit_ready high, checking every trit cycle-by-cycle;
  // optionally stall 3 cycles on trit index stall_at.
  task automatic emit_byte(input int d, input logic [7:0] b, input int base, input int stall_at);
    logic [1:0] e;
    for (int t = 0; t < 20 && !byte_ready[d]; t++) step();
    chk("byte_ready_before_accept", 32'(byte_ready[d]), 1);
    byte_in[d] = b; byte_valid[d] = 1'b1; trit_ready[d] = 1'b1;
    step();
    byte_valid[d] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (base + i >= nc(d)) break;
      e = digit(int'(b), i);
      if (i == stall_at) begin
        trit_ready[d] = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("stall_hold", 32'({trit_valid[d], trit_out[d], coef_idx[d]}),
              32'({1'b1, e, CW'(base + i)}));
        end
        trit_ready[d] = 1'b1;
      end
      chk("trit_valid", 32'(trit_valid[d]), 1);
      chk("trit_out", 32'(trit_out[d]), 32'(e));
      chk("coef_idx", 32'(coef_idx[d]), 32'(base + i));
      chk("trit_last", 32'(trit_last[d]), 32'(base + i == nc(d) - 1));
      chk("byte_ready_in_emit", 32'(byte_ready[d]), 0);
      step();
    end
    if (base + 5 >= nc(d)) begin
      chk("done_pulse", 32'(done[d]), 1);
      step();
      chk("after_done", 32'({done[d], busy[d], byte_ready[d], trit_valid[d]}), 0);
    end else begin
      chk("byte_ready_after_byte", 32'(byte_ready[d]), 1);
    end
  endtask

  // Randomized-run model state
  logic [1:0]    q[$];
  logic [1:0]    exp_t;
  logic [7:0]    rb;
  logic [1:0]    hold_t;
  logic [CW-1:0] hold_i;
  int            cnt;
  int            cyc;
  bit            fmt_m;
  bit            prev_stall;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b0; byte_in[d] = 8'd0;
      byte_valid[d] = 1'b0; trit_ready[d] = 1'b0;
    end
    step(); step();
    chk("reset_outputs_dut0", all_out(0), 0);
    chk("reset_outputs_dut1", all_out(1), 0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    step();
    chk("idle_no_busy", 32'({busy[0], byte_ready[0]}), 0);

    // 0xF2 then 0x64 (with stall), then reset mid-EMIT
    start[0] = 1'b1; step(); start[0] = 1'b0;
    chk("load_after_start", 32'({busy[0], byte_ready[0]}), 32'(2'b11));
    emit_byte(0, 8'hF2, 0, -1);
    chk("fmt_err_242", 32'(fmt_err[0]), 0);
    emit_byte(0, 8'h64, 5, 1);
    byte_in[0] = 8'h00; byte_valid[0] = 1'b1; step(); byte_valid[0] = 1'b0;
    chk("emit_before_reset", 32'(trit_valid[0]), 1);
    step();
    rst_n[0] = 1'b0; step();
    chk("reset_mid_emit", all_out(0), 0);
    rst_n[0] = 1'b1; step();
    chk("after_reset_release", all_out(0), 0);

    // Fresh polynomial: coef_idx 0..9 over 0x64, 0x00; then fmt_err stickiness
    start[0] = 1'b1; step(); start[0] = 1'b0;
    emit_byte(0, 8'h64, 0, -1);
    emit_byte(0, 8'h00, 5, -1);
    emit_byte(0, 8'd250, 10, -1);
    chk("fmt_err_set", 32'(fmt_err[0]), 1);
    emit_byte(0, 8'h05, 15, -1);
    chk("fmt_err_sticky", 32'(fmt_err[0]), 1);
    rst_n[0] = 1'b0; step(); rst_n[0] = 1'b1; step();
    chk("fmt_err_reset", 32'(fmt_err[0]), 0);

    // Randomized full polynomial against the digit queue model
    start[0] = 1'b1; step(); start[0] = 1'b0;
    cnt = 0; cyc = 0; fmt_m = 1'b0; prev_stall = 1'b0;
    while (cnt < N0 && cyc < 20000) begin
      rb = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(243, 255))
                                       : 8'($urandom_range(0, 242));
      byte_in[0]    = rb;
      byte_valid[0] = ($urandom_range(0, 3) != 0);
      trit_ready[0] = ($urandom_range(0, 3) != 0);
      if (prev_stall)
        chk("rand_hold", 32'({trit_out[0], coef_idx[0]}), 32'({hold_t, hold_i}));
      chk("rand_no_early_done", 32'(done[0]), 0);
      chk("rand_byte_ready", 32'(byte_ready[0]), 32'(q.size() == 0));
      chk("rand_trit_valid", 32'(trit_valid[0]), 32'(q.size() != 0));
      if (trit_valid[0])
        chk("rand_trit_last", 32'(trit_last[0]), 32'(cnt == N0 - 1));
      if (byte_valid[0] && byte_ready[0]) begin
        for (int i = 0; i < 5; i++) q.push_back(digit(int'(rb), i));
        if (rb > 8'd242) fmt_m = 1'b1;
      end
      if (trit_valid[0] && trit_ready[0]) begin
        exp_t = (q.size() != 0) ? q.pop_front() : 2'd3;
        chk("rand_trit_out", 32'(trit_out[0]), 32'(exp_t));
        chk("rand_coef_idx", 32'(coef_idx[0]), 32'(cnt));
        cnt++;
      end
      prev_stall = trit_valid[0] && !trit_ready[0];
      hold_t = trit_out[0];
      hold_i = coef_idx[0];
      step();
      cyc++;
    end
    byte_valid[0] = 1'b0;
    chk("rand_trit_count", 32'(cnt), 32'(N0));
    chk("rand_queue_drained", 32'(q.size()), 0);
    chk("rand_done", 32'(done[0]), 1);
    chk("rand_fmt_err", 32'(fmt_err[0]), 32'(fmt_m));
    step();
    chk("rand_idle", 32'({busy[0], byte_ready[0], done[0], trit_valid[0]}), 0);

    // NUM_COEF=7: partial final byte, extra byte never consumed
    start[1] = 1'b1; step(); start[1] = 1'b0;
    emit_byte(1, 8'h64, 0, -1);
    emit_byte(1, 8'hF2, 5, -1);
    byte_in[1] = 8'h11; byte_valid[1] = 1'b1;
    for (int s = 0; s < 5; s++) begin
      chk("third_byte_refused", 32'({byte_ready[1], busy[1], trit_valid[1]}), 0);
      step();
    end
    byte_valid[1] = 1'b0;

    // fmt_err survives done and clears on the next start
    start[1] = 1'b1; step(); start[1] = 1'b0;
    emit_byte(1, 8'd250, 0, -1);
    chk("fmt_err7_set", 32'(fmt_err[1]), 1);
    emit_byte(1, 8'h05, 5, -1);
    chk("fmt_err7_idle", 32'(fmt_err[1]), 1);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    chk("fmt_err7_cleared", 32'(fmt_err[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
